// File: rtl/traffic_pkg.sv
// Shared definitions for the junction controllers: arbiter states, crossing
// indices and lamp encodings common with the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WALK,
    ARB_CLEAR,
    ARB_RELEASE
  } arb_state_t;

  localparam int unsigned CR_M1 = 0;
  localparam int unsigned CR_M2 = 1;
  localparam int unsigned CR_MT = 2;
  localparam int unsigned CR_S  = 3;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching circularly. Returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int unsigned sum;
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    j     = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      sum = 32'(ptr) + off;
      if (sum >= 32'(N_REQ)) sum = sum - 32'(N_REQ);
      j = IDX_W'(sum);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/ped_crossing_arbiter.sv
// Pedestrian walk arbiter: latches button edges, grants one safe crossing at a
// time round-robin, freezes the light controller and times WALK then CLEAR.
module ped_crossing_arbiter
  import traffic_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WALK_TICKS  = 4,
  parameter int CLEAR_TICKS = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_REQ-1:0] ped_btn,
  input  logic [N_REQ-1:0] safe,
  input  logic             emerg,
  input  logic             hold_ack,
  output logic             hold_req,
  output logic [N_REQ-1:0] walk,
  output logic [N_REQ-1:0] clear_flash,
  output logic [N_REQ-1:0] pending
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [N_REQ-1:0] grant_oh;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] btn_q;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic             enter_walk;
  logic [N_REQ-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (pending & safe),
    .ptr   (rr_ptr),
    .grant (arb_oh),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // A re-press by the crossing currently being served must not queue it again.
  always_comb begin
    rise = ped_btn & ~btn_q;
    if (state == ARB_WALK || state == ARB_CLEAR) rise = rise & ~grant_oh;
    enter_walk = (state == ARB_REQ) && !emerg && ((safe & grant_oh) != '0) && hold_ack;
    clr = enter_walk ? grant_oh : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_oh <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      btn_q    <= '0;
      pending  <= '0;
    end else begin
      btn_q   <= ped_btn;
      pending <= (pending | rise) & ~clr;
      case (state)
        ARB_IDLE: begin
          if (!emerg && arb_valid) begin
            grant    <= arb_idx;
            grant_oh <= arb_oh;
            state    <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (emerg || ((safe & grant_oh) == '0)) begin
            state <= ARB_RELEASE;
          end else if (hold_ack) begin
            state <= ARB_WALK;
            cnt   <= '0;
          end
        end
        ARB_WALK: begin
          if (emerg) begin
            state <= ARB_RELEASE;
          end else if (!hold_ack) begin
            state <= ARB_CLEAR;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == CNT_W'(WALK_TICKS - 1)) begin
              state <= ARB_CLEAR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ARB_CLEAR: begin
          if (emerg) begin
            state <= ARB_RELEASE;
          end else if (tick) begin
            if (cnt == CNT_W'(CLEAR_TICKS - 1)) begin
              state  <= ARB_RELEASE;
              cnt    <= '0;
              rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ARB_RELEASE: begin
          if (!hold_ack) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Emergency gates the lamps and the freeze request in the same cycle.
  always_comb begin
    hold_req    = !emerg && (state == ARB_REQ || state == ARB_WALK || state == ARB_CLEAR);
    walk        = (!emerg && state == ARB_WALK)  ? grant_oh : '0;
    clear_flash = (!emerg && state == ARB_CLEAR) ? grant_oh : '0;
  end

endmodule

// File: tb/tb_ped_crossing_arbiter.sv
// Directed bench for ped_crossing_arbiter with hand-computed expectations.
module tb_ped_crossing_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick;
  logic [3:0] ped_btn = '0;
  logic [3:0] safe = '0;
  logic       emerg = 1'b0;
  logic       hold_ack;
  logic       hold_req;
  logic [3:0] walk;
  logic [3:0] clear_flash;
  logic [3:0] pending;

  logic auto_tick = 1'b0;
  logic tick_man  = 1'b0;
  logic auto_ack  = 1'b0;
  logic ack_man   = 1'b0;
  logic ack_q     = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  assign tick     = auto_tick | tick_man;
  assign hold_ack = auto_ack ? ack_q : ack_man;

  ped_crossing_arbiter #(
    .N_REQ(4), .WALK_TICKS(4), .CLEAR_TICKS(2), .CNT_W(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .ped_btn     (ped_btn),
    .safe        (safe),
    .emerg       (emerg),
    .hold_ack    (hold_ack),
    .hold_req    (hold_req),
    .walk        (walk),
    .clear_flash (clear_flash),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ack_q <= hold_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick_pulse();
    tick_man = 1'b1;
    cyc(1);
    tick_man = 1'b0;
    cyc(1);
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp);
    int k = 0;
    while (walk == 4'b0 && k < 40) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(walk), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((hold_req || walk != 4'b0 || clear_flash != 4'b0) && k < 40) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(hold_req), 32'd0);
  endtask

  initial begin
    cyc(3);
    chk("rst_hold_req", 32'(hold_req), 32'd0);
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_clear", 32'(clear_flash), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single request on S with manual ack and ticks.
    safe = 4'b1000;
    ped_btn = 4'b1000;
    cyc(1);
    chk("s_pending", 32'(pending), 32'h8);
    chk("s_no_hold_yet", 32'(hold_req), 32'd0);
    cyc(1);
    chk("s_hold_req", 32'(hold_req), 32'd1);
    chk("s_walk_before_ack", 32'(walk), 32'd0);
    ack_man = 1'b1;
    cyc(1);
    chk("s_walk", 32'(walk), 32'h8);
    chk("s_pending_clr", 32'(pending), 32'd0);
    repeat (3) tick_pulse();
    chk("s_walk_3ticks", 32'(walk), 32'h8);
    ped_btn = 4'b0000;
    cyc(1);
    ped_btn = 4'b1000;
    cyc(1);
    chk("s_repress_ignored", 32'(pending), 32'd0);
    tick_pulse();
    chk("s_clear", 32'(clear_flash), 32'h8);
    chk("s_walk_off", 32'(walk), 32'd0);
    chk("s_hold_in_clear", 32'(hold_req), 32'd1);
    tick_pulse();
    chk("s_clear_1tick", 32'(clear_flash), 32'h8);
    tick_pulse();
    chk("s_release_hold", 32'(hold_req), 32'd0);
    chk("s_release_lamp", 32'(clear_flash), 32'd0);
    chk("s_release_pend", 32'(pending), 32'd0);
    ack_man = 1'b0;
    ped_btn = 4'b0000;
    cyc(3);

    // Round-robin with all crossings requesting.
    auto_tick = 1'b1;
    auto_ack  = 1'b1;
    safe      = 4'b1111;
    ped_btn   = 4'b1111;
    expect_grant("rr_g0", 4'b0001);
    wait_idle("rr_i0");
    expect_grant("rr_g1", 4'b0010);
    ped_btn = 4'b1010;
    cyc(1);
    ped_btn = 4'b1111;
    cyc(1);
    wait_idle("rr_i1");
    expect_grant("rr_g2", 4'b0100);
    wait_idle("rr_i2");
    expect_grant("rr_g3", 4'b1000);
    wait_idle("rr_i3");
    expect_grant("rr_g0b", 4'b0001);
    wait_idle("rr_i0b");
    ped_btn = 4'b0000;
    cyc(3);
    chk("rr_pending_empty", 32'(pending), 32'd0);

    // Emergency abort of crossing 1; presses during emergency are latched.
    auto_tick = 1'b0;
    ped_btn = 4'b0010;
    expect_grant("em_grant", 4'b0010);
    emerg = 1'b1;
    #1;
    chk("em_walk_off", 32'(walk), 32'd0);
    chk("em_hold_off", 32'(hold_req), 32'd0);
    cyc(1);
    ped_btn = 4'b0000;
    cyc(1);
    ped_btn = 4'b0011;
    cyc(1);
    chk("em_latched", 32'(pending), 32'h3);
    cyc(3);
    chk("em_idle_hold", 32'(hold_req), 32'd0);
    emerg = 1'b0;
    expect_grant("em_regrant", 4'b0010);
    auto_tick = 1'b1;
    wait_idle("em_i1");
    expect_grant("em_next", 4'b0001);
    wait_idle("em_i0");
    ped_btn = 4'b0000;
    cyc(3);

    // Safety: no grant without safe; safe loss in REQ releases and keeps pending.
    auto_tick = 1'b0;
    auto_ack  = 1'b0;
    ack_man   = 1'b0;
    safe      = 4'b0000;
    ped_btn   = 4'b0100;
    cyc(4);
    chk("sf_pending", 32'(pending), 32'h4);
    chk("sf_no_hold", 32'(hold_req), 32'd0);
    safe = 4'b0100;
    cyc(1);
    chk("sf_req", 32'(hold_req), 32'd1);
    safe = 4'b0000;
    cyc(1);
    chk("sf_released", 32'(hold_req), 32'd0);
    chk("sf_pending_kept", 32'(pending), 32'h4);
    cyc(2);
    safe      = 4'b0100;
    auto_ack  = 1'b1;
    auto_tick = 1'b1;
    expect_grant("sf_grant", 4'b0100);
    wait_idle("sf_idle");
    ped_btn = 4'b0000;
    cyc(3);

    // Ack loss during WALK goes straight to CLEAR.
    auto_tick = 1'b0;
    auto_ack  = 1'b0;
    ack_man   = 1'b0;
    safe      = 4'b1111;
    ped_btn   = 4'b1000;
    cyc(2);
    chk("al_req", 32'(hold_req), 32'd1);
    ack_man = 1'b1;
    cyc(1);
    chk("al_walk", 32'(walk), 32'h8);
    ack_man = 1'b0;
    cyc(1);
    chk("al_clear", 32'(clear_flash), 32'h8);
    chk("al_walk_off", 32'(walk), 32'd0);
    tick_pulse();
    tick_pulse();
    chk("al_released", 32'(hold_req), 32'd0);
    ped_btn = 4'b0000;
    cyc(3);

    // Asynchronous reset in the middle of a WALK.
    safe     = 4'b0001;
    auto_ack = 1'b1;
    ped_btn  = 4'b0101;
    expect_grant("rs_pre_walk", 4'b0001);
    chk("rs_pre_pending", 32'(pending), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rs_walk", 32'(walk), 32'd0);
    chk("rs_hold", 32'(hold_req), 32'd0);
    chk("rs_pending", 32'(pending), 32'd0);
    auto_ack = 1'b0;
    ped_btn  = 4'b0000;
    cyc(2);
    rst_n = 1'b1;
    safe  = 4'b1111;
    cyc(3);
    chk("rs_idle_hold", 32'(hold_req), 32'd0);
    chk("rs_idle_walk", 32'(walk), 32'd0);
    chk("rs_idle_pend", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
